// File: rtl/dec_stage_pkg.sv
// dec_stage_pkg
// Shared definitions for the decode stage: RV32 opcode constants, lane
// indices of the one-hot lane select, per-lane operation-bus bit indices
// and the layout of the fixed-width part of a decoded bundle.
// No ports (package).
package dec_stage_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Fully fixed SYSTEM encodings
   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

   // Lane indices into o_usele
   localparam int SELE_W = 5;
   localparam logic [2:0] SELE_ALU = 3'd0;
   localparam logic [2:0] SELE_BJU = 3'd1;
   localparam logic [2:0] SELE_LSU = 3'd2;
   localparam logic [2:0] SELE_MDU = 3'd3;
   localparam logic [2:0] SELE_SYS = 3'd4;

   // ALU lane operations (10)
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   // BJU lane operations (9)
   localparam logic [3:0] BJU_JAL   = 4'd0;
   localparam logic [3:0] BJU_JALR  = 4'd1;
   localparam logic [3:0] BJU_BEQ   = 4'd2;
   localparam logic [3:0] BJU_BNE   = 4'd3;
   localparam logic [3:0] BJU_BLT   = 4'd4;
   localparam logic [3:0] BJU_BGE   = 4'd5;
   localparam logic [3:0] BJU_BLTU  = 4'd6;
   localparam logic [3:0] BJU_BGEU  = 4'd7;
   localparam logic [3:0] BJU_AUIPC = 4'd8;

   // LSU lane operations (8)
   localparam logic [3:0] LSU_LB  = 4'd0;
   localparam logic [3:0] LSU_LH  = 4'd1;
   localparam logic [3:0] LSU_LW  = 4'd2;
   localparam logic [3:0] LSU_LBU = 4'd3;
   localparam logic [3:0] LSU_LHU = 4'd4;
   localparam logic [3:0] LSU_SB  = 4'd5;
   localparam logic [3:0] LSU_SH  = 4'd6;
   localparam logic [3:0] LSU_SW  = 4'd7;

   // MDU lane operations (8)
   localparam logic [3:0] MDU_MUL    = 4'd0;
   localparam logic [3:0] MDU_MULH   = 4'd1;
   localparam logic [3:0] MDU_MULHSU = 4'd2;
   localparam logic [3:0] MDU_MULHU  = 4'd3;
   localparam logic [3:0] MDU_DIV    = 4'd4;
   localparam logic [3:0] MDU_DIVU   = 4'd5;
   localparam logic [3:0] MDU_REM    = 4'd6;
   localparam logic [3:0] MDU_REMU   = 4'd7;

   // SYS lane operations (9)
   localparam logic [3:0] SYS_CSRRW  = 4'd0;
   localparam logic [3:0] SYS_CSRRS  = 4'd1;
   localparam logic [3:0] SYS_CSRRC  = 4'd2;
   localparam logic [3:0] SYS_CSRRWI = 4'd3;
   localparam logic [3:0] SYS_CSRRSI = 4'd4;
   localparam logic [3:0] SYS_CSRRCI = 4'd5;
   localparam logic [3:0] SYS_ECALL  = 4'd6;
   localparam logic [3:0] SYS_EBREAK = 4'd7;
   localparam logic [3:0] SYS_MRET   = 4'd8;

   // Largest lane needs 10 bus bits
   localparam int OPB_MIN_W = 10;

   // Decoded bundle minus the parameter-sized PC and operation bus
   typedef struct packed {
      logic [SELE_W-1:0] usele;
      logic              rs1_ren;
      logic              rs2_ren;
      logic              rd_wen;
      logic [4:0]        rs1_idx;
      logic [4:0]        rs2_idx;
      logic [4:0]        rd_idx;
      logic [31:0]       im;
      logic              ilgl;
   } dec_fix_t;

   localparam int BNDL_W = $bits(dec_fix_t);

endpackage

// File: rtl/dec_core.sv
// dec_core
// Purely combinational RV32I (+M, +Zicsr) decoder.
// Ports:
//   instr  in  32      instruction word
//   opb    out OPB_W   one-hot operation within the selected lane
//   fix    out BNDL_W  packed dec_fix_t: lane, enables, indices, imm, ilgl
// Illegal encodings produce ilgl = 1 with lane, operation and all
// register enables forced to zero.
module dec_core
   import dec_stage_pkg::*;
#(
   parameter int EN_M   = 1,
   parameter int EN_CSR = 1,
   parameter int OPB_W  = 16   // must be >= OPB_MIN_W
) (
   input  logic [31:0]       instr,
   output logic [OPB_W-1:0]  opb,
   output logic [BNDL_W-1:0] fix
);

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'b0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_z  = {27'b0, instr[19:15]};

   logic        legal;
   logic [2:0]  lane;
   logic [3:0]  op;
   logic        rs1_use, rs2_use, rd_use;
   logic [31:0] im;

   always_comb begin
      legal   = 1'b0;
      lane    = SELE_ALU;
      op      = ALU_ADD;
      rs1_use = 1'b0;
      rs2_use = 1'b0;
      rd_use  = 1'b0;
      im      = 32'b0;
      case (opcode)
         OPC_LUI: begin
            legal = 1'b1; lane = SELE_ALU; op = ALU_ADD; rd_use = 1'b1; im = imm_u;
         end
         OPC_AUIPC: begin
            legal = 1'b1; lane = SELE_BJU; op = BJU_AUIPC; rd_use = 1'b1; im = imm_u;
         end
         OPC_JAL: begin
            legal = 1'b1; lane = SELE_BJU; op = BJU_JAL; rd_use = 1'b1; im = imm_j;
         end
         OPC_JALR: begin
            legal = (f3 == 3'b000); lane = SELE_BJU; op = BJU_JALR;
            rs1_use = 1'b1; rd_use = 1'b1; im = imm_i;
         end
         OPC_BRANCH: begin
            legal = 1'b1; lane = SELE_BJU; rs1_use = 1'b1; rs2_use = 1'b1; im = imm_b;
            case (f3)
               3'b000:  op = BJU_BEQ;
               3'b001:  op = BJU_BNE;
               3'b100:  op = BJU_BLT;
               3'b101:  op = BJU_BGE;
               3'b110:  op = BJU_BLTU;
               3'b111:  op = BJU_BGEU;
               default: legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            legal = 1'b1; lane = SELE_LSU; rs1_use = 1'b1; rd_use = 1'b1; im = imm_i;
            case (f3)
               3'b000:  op = LSU_LB;
               3'b001:  op = LSU_LH;
               3'b010:  op = LSU_LW;
               3'b100:  op = LSU_LBU;
               3'b101:  op = LSU_LHU;
               default: legal = 1'b0;
            endcase
         end
         OPC_STORE: begin
            legal = 1'b1; lane = SELE_LSU; rs1_use = 1'b1; rs2_use = 1'b1; im = imm_s;
            case (f3)
               3'b000:  op = LSU_SB;
               3'b001:  op = LSU_SH;
               3'b010:  op = LSU_SW;
               default: legal = 1'b0;
            endcase
         end
         OPC_OPIMM: begin
            legal = 1'b1; lane = SELE_ALU; rs1_use = 1'b1; rd_use = 1'b1; im = imm_i;
            case (f3)
               3'b000: op = ALU_ADD;
               3'b010: op = ALU_SLT;
               3'b011: op = ALU_SLTU;
               3'b100: op = ALU_XOR;
               3'b110: op = ALU_OR;
               3'b111: op = ALU_AND;
               // RV32 shifts: shamt is 5 bits, so instr[25] must be clear
               3'b001: begin op = ALU_SLL; legal = (f7 == 7'b0000000); end
               default: begin
                  op    = (f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
               end
            endcase
         end
         OPC_OP: begin
            rs1_use = 1'b1; rs2_use = 1'b1; rd_use = 1'b1;
            if (f7 == 7'b0000000) begin
               legal = 1'b1; lane = SELE_ALU;
               case (f3)
                  3'b000:  op = ALU_ADD;
                  3'b001:  op = ALU_SLL;
                  3'b010:  op = ALU_SLT;
                  3'b011:  op = ALU_SLTU;
                  3'b100:  op = ALU_XOR;
                  3'b101:  op = ALU_SRL;
                  3'b110:  op = ALU_OR;
                  default: op = ALU_AND;
               endcase
            end else if (f7 == 7'b0100000) begin
               lane = SELE_ALU;
               op   = (f3 == 3'b101) ? ALU_SRA : ALU_SUB;
               legal = (f3 == 3'b000) || (f3 == 3'b101);
            end else if ((f7 == 7'b0000001) && (EN_M != 0)) begin
               legal = 1'b1; lane = SELE_MDU;
               case (f3)
                  3'b000:  op = MDU_MUL;
                  3'b001:  op = MDU_MULH;
                  3'b010:  op = MDU_MULHSU;
                  3'b011:  op = MDU_MULHU;
                  3'b100:  op = MDU_DIV;
                  3'b101:  op = MDU_DIVU;
                  3'b110:  op = MDU_REM;
                  default: op = MDU_REMU;
               endcase
            end
         end
         OPC_SYSTEM: begin
            if (EN_CSR != 0) begin
               lane = SELE_SYS;
               case (f3)
                  3'b001: begin legal = 1'b1; op = SYS_CSRRW;  rs1_use = 1'b1; rd_use = 1'b1; im = imm_i; end
                  3'b010: begin legal = 1'b1; op = SYS_CSRRS;  rs1_use = 1'b1; rd_use = 1'b1; im = imm_i; end
                  3'b011: begin legal = 1'b1; op = SYS_CSRRC;  rs1_use = 1'b1; rd_use = 1'b1; im = imm_i; end
                  // Immediate forms reuse the rs1 field as a 5-bit zimm
                  3'b101: begin legal = 1'b1; op = SYS_CSRRWI; rd_use = 1'b1; im = imm_z; end
                  3'b110: begin legal = 1'b1; op = SYS_CSRRSI; rd_use = 1'b1; im = imm_z; end
                  3'b111: begin legal = 1'b1; op = SYS_CSRRCI; rd_use = 1'b1; im = imm_z; end
                  3'b000: begin
                     if (instr == INSTR_ECALL) begin
                        legal = 1'b1; op = SYS_ECALL;
                     end else if (instr == INSTR_EBREAK) begin
                        legal = 1'b1; op = SYS_EBREAK;
                     end else if (instr == INSTR_MRET) begin
                        legal = 1'b1; op = SYS_MRET;
                     end
                  end
                  default: legal = 1'b0;
               endcase
            end
         end
         default: legal = 1'b0;
      endcase
      if ((instr == 32'h0000_0000) || (instr == 32'hFFFF_FFFF)) begin
         legal = 1'b0;
      end
   end

   // Index -> one-hot expansion, gated by legality so illegal bundles
   // carry an all-zero lane and operation.
   logic [SELE_W-1:0] usele;
   genvar gi;
   generate
      for (gi = 0; gi < SELE_W; gi++) begin : g_lane
         assign usele[gi] = legal & (32'(lane) == gi);
      end
      for (gi = 0; gi < OPB_W; gi++) begin : g_opb
         assign opb[gi] = legal & (32'(op) == gi);
      end
   endgenerate

   dec_fix_t fix_s;
   assign fix_s.usele   = usele;
   assign fix_s.rs1_ren = legal & rs1_use;
   assign fix_s.rs2_ren = legal & rs2_use;
   assign fix_s.rd_wen  = legal & rd_use & (instr[11:7] != 5'd0);
   assign fix_s.rs1_idx = instr[19:15];
   assign fix_s.rs2_idx = instr[24:20];
   assign fix_s.rd_idx  = instr[11:7];
   assign fix_s.im      = im;
   assign fix_s.ilgl    = ~legal;
   assign fix           = fix_s;

endmodule

// File: rtl/dec_stage.sv
// dec_stage
// Registered decode stage: dec_core followed by a 2-entry skid buffer
// (MAIN drives the outputs, SKID absorbs one instruction while issue
// stalls), so i_ready never reaches o_ready combinationally.
// Ports:
//   clk, rst_n (async, active-low), i_flush
//   i_valid/o_ready/i_instr/i_pc          fetch side
//   o_valid/i_ready                        issue side handshake
//   o_pc, o_opb, o_usele, o_rs*_ren, o_rd_wen, o_*_idx, o_im, o_ilgl
//                                          decoded bundle (from MAIN)
module dec_stage
   import dec_stage_pkg::*;
#(
   parameter int EN_M   = 1,
   parameter int EN_CSR = 1,
   parameter int OPB_W  = 16,
   parameter int PC_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [31:0]      i_instr,
   input  logic [PC_W-1:0]  i_pc,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [PC_W-1:0]  o_pc,
   output logic [OPB_W-1:0] o_opb,
   output logic [4:0]       o_usele,
   output logic             o_rs1_ren,
   output logic             o_rs2_ren,
   output logic             o_rd_wen,
   output logic [4:0]       o_rs1_idx,
   output logic [4:0]       o_rs2_idx,
   output logic [4:0]       o_rd_idx,
   output logic [31:0]      o_im,
   output logic             o_ilgl
);

   localparam int ENT_W = PC_W + OPB_W + BNDL_W;

   logic [OPB_W-1:0]  dec_opb;
   logic [BNDL_W-1:0] dec_fix;
   logic [ENT_W-1:0]  dec_ent;

   dec_core #(
      .EN_M   (EN_M),
      .EN_CSR (EN_CSR),
      .OPB_W  (OPB_W)
   ) u_core (
      .instr (i_instr),
      .opb   (dec_opb),
      .fix   (dec_fix)
   );

   assign dec_ent = {i_pc, dec_opb, dec_fix};

   logic             main_vld_reg, main_vld_next;
   logic             skid_vld_reg, skid_vld_next;
   logic [ENT_W-1:0] main_data_reg, main_data_next;
   logic [ENT_W-1:0] skid_data_reg, skid_data_next;
   logic             in_fire, out_fire;

   assign in_fire  = i_valid & ~skid_vld_reg;
   assign out_fire = main_vld_reg & i_ready;

   // SKID can only be full while MAIN is full, so "MAIN empty" implies
   // SKID empty and the input always goes straight to MAIN.
   always_comb begin
      main_vld_next  = main_vld_reg;
      skid_vld_next  = skid_vld_reg;
      main_data_next = main_data_reg;
      skid_data_next = skid_data_reg;
      if (i_flush) begin
         main_vld_next = 1'b0;
         skid_vld_next = 1'b0;
      end else if (out_fire && skid_vld_reg) begin
         // in_fire is impossible here: o_ready is low while SKID is full
         main_data_next = skid_data_reg;
         skid_vld_next  = 1'b0;
      end else if (in_fire && (!main_vld_reg || out_fire)) begin
         main_vld_next  = 1'b1;
         main_data_next = dec_ent;
      end else if (in_fire) begin
         skid_vld_next  = 1'b1;
         skid_data_next = dec_ent;
      end else if (out_fire) begin
         main_vld_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_vld_reg  <= 1'b0;
         skid_vld_reg  <= 1'b0;
         main_data_reg <= '0;
         skid_data_reg <= '0;
      end else begin
         main_vld_reg  <= main_vld_next;
         skid_vld_reg  <= skid_vld_next;
         main_data_reg <= main_data_next;
         skid_data_reg <= skid_data_next;
      end
   end

   dec_fix_t main_fix;
   assign main_fix = main_data_reg[BNDL_W-1:0];

   assign o_ready   = ~skid_vld_reg;
   assign o_valid   = main_vld_reg;
   assign o_pc      = main_data_reg[ENT_W-1 -: PC_W];
   assign o_opb     = main_data_reg[BNDL_W +: OPB_W];
   assign o_usele   = main_fix.usele;
   assign o_rs1_ren = main_fix.rs1_ren;
   assign o_rs2_ren = main_fix.rs2_ren;
   assign o_rd_wen  = main_fix.rd_wen;
   assign o_rs1_idx = main_fix.rs1_idx;
   assign o_rs2_idx = main_fix.rs2_idx;
   assign o_rd_idx  = main_fix.rd_idx;
   assign o_im      = main_fix.im;
   assign o_ilgl    = main_fix.ilgl;

endmodule

// File: tb/tb_dec_stage.sv
// tb_dec_stage
// Scoreboard bench for dec_stage. A second instance with M and CSR
// disabled shares all inputs. Inputs change and outputs are sampled on
// the falling edge; a bench-side occupancy model decides acceptance.
module tb_dec_stage;
   import dec_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_flush = 1'b0;
   logic        i_valid = 1'b0;
   logic [31:0] i_instr = 32'b0;
   logic [31:0] i_pc = 32'b0;
   logic        i_ready = 1'b0;

   logic        o_ready, o_valid, o_rs1_ren, o_rs2_ren, o_rd_wen, o_ilgl;
   logic [31:0] o_pc, o_im;
   logic [15:0] o_opb;
   logic [4:0]  o_usele, o_rs1_idx, o_rs2_idx, o_rd_idx;

   logic        m0_ready, m0_valid, m0_rs1_ren, m0_rs2_ren, m0_rd_wen, m0_ilgl;
   logic [31:0] m0_pc, m0_im;
   logic [15:0] m0_opb;
   logic [4:0]  m0_usele, m0_rs1_idx, m0_rs2_idx, m0_rd_idx;

   always #5 clk = ~clk;

   dec_stage #(.EN_M(1), .EN_CSR(1), .OPB_W(16), .PC_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid),
      .o_ready(o_ready), .i_instr(i_instr), .i_pc(i_pc), .o_valid(o_valid),
      .i_ready(i_ready), .o_pc(o_pc), .o_opb(o_opb), .o_usele(o_usele),
      .o_rs1_ren(o_rs1_ren), .o_rs2_ren(o_rs2_ren), .o_rd_wen(o_rd_wen),
      .o_rs1_idx(o_rs1_idx), .o_rs2_idx(o_rs2_idx), .o_rd_idx(o_rd_idx),
      .o_im(o_im), .o_ilgl(o_ilgl)
   );

   dec_stage #(.EN_M(0), .EN_CSR(0), .OPB_W(16), .PC_W(32)) u_dut_m0 (
      .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid),
      .o_ready(m0_ready), .i_instr(i_instr), .i_pc(i_pc), .o_valid(m0_valid),
      .i_ready(i_ready), .o_pc(m0_pc), .o_opb(m0_opb), .o_usele(m0_usele),
      .o_rs1_ren(m0_rs1_ren), .o_rs2_ren(m0_rs2_ren), .o_rd_wen(m0_rd_wen),
      .o_rs1_idx(m0_rs1_idx), .o_rs2_idx(m0_rs2_idx), .o_rd_idx(m0_rd_idx),
      .o_im(m0_im), .o_ilgl(m0_ilgl)
   );

   typedef struct {
      logic [31:0] instr;
      int          lane;
      int          op;
      bit          r1, r2, wd;
      logic [31:0] im;
      bit          chk_im;
      bit          ilgl;
      bit          m0_ilgl;  // expected ilgl with M and CSR disabled
   } tv_t;

   typedef struct {
      logic [31:0] pc;
      int          idx;
   } exp_t;

   tv_t  tbl[15];
   exp_t sb_q[$];
   int   occ = 0;
   int   seq = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_tv(input int i, input logic [31:0] instr, input int lane, input int op,
                         input bit r1, input bit r2, input bit wd, input logic [31:0] im,
                         input bit chk_im, input bit ilgl, input bit m0_ilgl);
      tbl[i].instr = instr; tbl[i].lane = lane; tbl[i].op = op;
      tbl[i].r1 = r1; tbl[i].r2 = r2; tbl[i].wd = wd; tbl[i].im = im;
      tbl[i].chk_im = chk_im; tbl[i].ilgl = ilgl; tbl[i].m0_ilgl = m0_ilgl;
   endtask

   task automatic cmp_bundle(input string p, input int idx, input logic [31:0] epc, input bit eilgl,
                             input logic [31:0] pc, input logic [15:0] opb, input logic [4:0] usele,
                             input logic r1, input logic r2, input logic wd,
                             input logic [4:0] i1, input logic [4:0] i2, input logic [4:0] id,
                             input logic [31:0] im, input logic il);
      tv_t t;
      logic [31:0] ins;
      t = tbl[idx];
      ins = t.instr;
      chk({p, "_pc"}, pc, epc);
      chk({p, "_ilgl"}, il, eilgl);
      chk({p, "_usele"}, usele, eilgl ? 64'd0 : (64'd1 << t.lane));
      chk({p, "_opb"}, opb, eilgl ? 64'd0 : (64'd1 << t.op));
      if (!eilgl) begin
         chk({p, "_rs1_ren"}, r1, t.r1);
         chk({p, "_rs2_ren"}, r2, t.r2);
         chk({p, "_rd_wen"}, wd, t.wd);
         if (t.r1) chk({p, "_rs1_idx"}, i1, ins[19:15]);
         if (t.r2) chk({p, "_rs2_idx"}, i2, ins[24:20]);
         if (t.wd) chk({p, "_rd_idx"}, id, ins[11:7]);
         if (t.chk_im) chk({p, "_im"}, im, t.im);
      end
   endtask

   // One clock cycle: drive at the falling edge, check the registered
   // outputs against the model, then advance to the next falling edge.
   task automatic cycle(input bit v, input int idx, input bit rdy, input bit fl, output bit acc);
      bit   in_f, out_f;
      exp_t e;
      i_valid = v;
      i_instr = tbl[idx].instr;
      i_pc    = 32'h1000 + 32'(seq) * 4;
      i_ready = rdy;
      i_flush = fl;
      chk("valid", o_valid, occ > 0);
      chk("ready", o_ready, occ < 2);
      chk("m0_valid", m0_valid, occ > 0);
      chk("m0_ready", m0_ready, occ < 2);
      out_f = (occ > 0) && rdy;
      in_f  = v && (occ < 2);
      if (out_f) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            e = sb_q.pop_front();
            $display("OUT pc=%08h instr=%08h usele=%05b opb=%04h ilgl=%0b m0_ilgl=%0b",
                     o_pc, tbl[e.idx].instr, o_usele, o_opb, o_ilgl, m0_ilgl);
            cmp_bundle("dut", e.idx, e.pc, tbl[e.idx].ilgl, o_pc, o_opb, o_usele,
                       o_rs1_ren, o_rs2_ren, o_rd_wen, o_rs1_idx, o_rs2_idx, o_rd_idx,
                       o_im, o_ilgl);
            cmp_bundle("m0", e.idx, e.pc, tbl[e.idx].m0_ilgl, m0_pc, m0_opb, m0_usele,
                       m0_rs1_ren, m0_rs2_ren, m0_rd_wen, m0_rs1_idx, m0_rs2_idx, m0_rd_idx,
                       m0_im, m0_ilgl);
         end
      end
      acc = 1'b0;
      if (fl) begin
         sb_q.delete();
         occ = 0;
      end else begin
         if (in_f) begin
            e.pc = i_pc; e.idx = idx;
            sb_q.push_back(e);
            seq++;
            acc = 1'b1;
         end
         occ = occ + (in_f ? 1 : 0) - (out_f ? 1 : 0);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      bit acc;
      int k;
      int lst[3];
      //      idx instr          lane      op          r1 r2 wd im            cim il m0
      set_tv(0,  32'hFFF00293, SELE_ALU, ALU_ADD,    1, 0, 1, 32'hFFFFFFFF, 1, 0, 0);
      set_tv(1,  32'h023100B3, SELE_MDU, MDU_MUL,    1, 1, 1, 32'h0,        0, 0, 1);
      set_tv(2,  32'h004100E7, SELE_BJU, BJU_JALR,   1, 0, 1, 32'h4,        1, 0, 0);
      set_tv(3,  32'h02109093, 0,        0,          0, 0, 0, 32'h0,        0, 1, 1);
      set_tv(4,  32'h00000000, 0,        0,          0, 0, 0, 32'h0,        0, 1, 1);
      set_tv(5,  32'hFFFFFFFF, 0,        0,          0, 0, 0, 32'h0,        0, 1, 1);
      set_tv(6,  32'h123453B7, SELE_ALU, ALU_ADD,    0, 0, 1, 32'h12345000, 1, 0, 0);
      set_tv(7,  32'h0020A423, SELE_LSU, LSU_SW,     1, 1, 0, 32'h8,        1, 0, 0);
      set_tv(8,  32'hFE208EE3, SELE_BJU, BJU_BEQ,    1, 1, 0, 32'hFFFFFFFC, 1, 0, 0);
      set_tv(9,  32'h3002D1F3, SELE_SYS, SYS_CSRRWI, 0, 0, 1, 32'h5,        1, 0, 1);
      set_tv(10, 32'h00000073, SELE_SYS, SYS_ECALL,  0, 0, 0, 32'h0,        0, 0, 1);
      set_tv(11, 32'h40628233, SELE_ALU, ALU_SUB,    1, 1, 1, 32'h0,        0, 0, 0);
      set_tv(12, 32'h00208033, SELE_ALU, ALU_ADD,    1, 1, 0, 32'h0,        0, 0, 0);
      set_tv(13, 32'hFF85A503, SELE_LSU, LSU_LW,     1, 0, 1, 32'hFFFFFFF8, 1, 0, 0);
      set_tv(14, 32'h40315093, SELE_ALU, ALU_SRA,    1, 0, 1, 32'h0,        0, 0, 0);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", o_valid, 0);
      chk("rst_ready", o_ready, 1);
      chk("rst_pc", o_pc, 0);
      chk("rst_opb", o_opb, 0);
      chk("rst_im", o_im, 0);
      chk("rst_usele", o_usele, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full-rate stream with issue always ready
      for (int i = 0; i < 15; i++) cycle(1, i, 1, 0, acc);
      for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, acc);

      // Stall: three back-to-back, issue blocked; only two fit
      lst[0] = 0; lst[1] = 6; lst[2] = 11;
      k = 0;
      for (int c = 0; c < 4; c++) begin
         cycle(1, lst[k], 0, 0, acc);
         if (acc && k < 2) k++;
      end
      chk("stall_accepted", k, 2);
      chk("stall_ready_low", o_ready, 0);
      for (int c = 0; c < 8 && k < 3; c++) begin
         cycle(1, lst[k], 1, 0, acc);
         if (acc) k++;
      end
      chk("stall_third_taken", k, 3);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, acc);
      chk("drain_empty", sb_q.size(), 0);
      chk("drain_ready", o_ready, 1);

      // Flush with both entries full and a valid input
      cycle(1, 13, 0, 0, acc);
      cycle(1, 3, 0, 0, acc);
      cycle(1, 1, 0, 1, acc);
      cycle(0, 0, 1, 0, acc);
      // Flush while an input would otherwise be accepted
      cycle(1, 4, 0, 0, acc);
      cycle(1, 5, 0, 1, acc);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, acc);

      // Asynchronous reset while a bundle is presented
      cycle(1, 8, 0, 0, acc);
      chk("pre_arst_valid", o_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", o_valid, 0);
      chk("arst_ready", o_ready, 1);
      chk("arst_m0_valid", m0_valid, 0);
      sb_q.delete();
      occ = 0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 0, 1, 0, acc);
      cycle(1, 2, 1, 0, acc);
      cycle(0, 0, 1, 0, acc);
      cycle(0, 0, 1, 0, acc);
      chk("final_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
